err_power_monitor: RTL and testbench

Convergence monitor that sits directly downstream of the adaptive FIR. It consumes the registered error sample (`o_filter`, S(21,20)) every valid cycle and squares it. It smooths the squared error with a leaky integrator to estimate error power, and raises a hysteretic "converged" flag once power stays below a threshold for a programmable number of samples. It also tracks the peak squared error since the last clear, for debug readout.

---
 rtl/err_power_monitor.sv | 168 ++++++++++++++++
 tb/tb_err_power_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/err_power_monitor.sv
// err_power_monitor: squares the adaptive-FIR error, smooths it with a leaky
// integrator to estimate error power, tracks the peak squared error and runs
// a hysteretic lock FSM that reports convergence.
//
// Handshake: i_valid qualifies i_error on the cycle it is high; there is no
// backpressure. Valid travels with the data through every pipeline stage,
// and o_power_valid is high for exactly the cycles in which o_power holds a
// freshly updated accumulator value.
module err_power_monitor #(
  parameter int NB_DATA  = 21,
  parameter int NBF_DATA = 20,
  parameter int NB_POW   = 24,
  parameter int SHIFT    = 6,
  parameter int HOLD     = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NB_DATA-1:0]         i_error,
  input  logic                       i_valid,
  input  logic [NB_POW-1:0]          i_thr_lo,
  input  logic [NB_POW-1:0]          i_thr_hi,
  input  logic                       i_clear_peak,
  output logic [NB_POW-1:0]          o_power,
  output logic                       o_power_valid,
  output logic                       o_converged,
  output logic [NB_POW-1:0]          o_peak,
  output logic [1:0]                 o_dbg_state,
  output logic [$clog2(HOLD+1)-1:0]  o_dbg_cnt
);

  localparam int ACC_W  = NB_POW + SHIFT;
  localparam int CNT_W  = $clog2(HOLD + 1);
  // The square is S(42,40); keeping bits [2*NBF_DATA : SQ_LSB] gives U(NB_POW,NB_POW-1).
  localparam int SQ_LSB = 2 * NBF_DATA - NB_POW + 1;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  logic signed [NB_DATA-1:0] err_q, err_d;
  logic                      vld1_q, vld1_d;
  logic [NB_POW-1:0]         sq_q, sq_d;
  logic                      vld2_q, vld2_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic                      pv_q, pv_d;
  logic [NB_POW-1:0]         peak_q, peak_d;
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [2*NB_DATA-1:0] prod_c;
  logic [NB_POW-1:0]           sq_c;
  logic [ACC_W:0]              acc_sum_c;
  logic [CNT_W-1:0]            cnt_inc_c;

  // Datapath: input register, squaring, leaky integration and peak tracking.
  always_comb begin
    err_d     = err_q;
    vld1_d    = vld1_q;
    sq_d      = sq_q;
    vld2_d    = vld2_q;
    acc_d     = acc_q;
    pv_d      = pv_q;
    peak_d    = peak_q;
    prod_c    = '0;
    sq_c      = '0;
    acc_sum_c = '0;

    // Stage 1: capture the sample and its qualifier every cycle.
    err_d  = $signed(i_error);
    vld1_d = i_valid;

    // Stage 2: the square is never negative and at most 1.0, so the top bit is
    // always zero and floor truncation of the next NB_POW bits is exact at -1.0.
    prod_c = err_q * err_q;
    sq_c   = NB_POW'(prod_c >> SQ_LSB);
    sq_d   = sq_c;
    vld2_d = vld1_q;

    // Stage 3: acc <- acc - acc/2^SHIFT + sq, saturating at all-ones.
    acc_sum_c = {1'b0, acc_q - (acc_q >> SHIFT)} + {{(SHIFT + 1){1'b0}}, sq_q};
    if (vld2_q) begin
      acc_d = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
    end
    pv_d = vld2_q;

    // Peak follows the stage-2 square; a clear restarts tracking from the
    // square being produced this cycle (or zero when there is none).
    if (i_clear_peak) begin
      peak_d = vld1_q ? sq_c : '0;
    end else if (vld1_q && (sq_c > peak_q)) begin
      peak_d = sq_c;
    end
  end

  // Lock FSM next-state: only advances on cycles carrying a fresh power value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc_c = cnt_q + 1'b1;
    if (pv_q) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (o_power < i_thr_lo) begin
            cnt_d   = CNT_W'(1);
            state_d = (HOLD == 1) ? ST_LOCKED : ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (o_power >= i_thr_lo) begin
            cnt_d   = '0;
            state_d = ST_UNLOCKED;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == HOLD_C) begin
              state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (o_power > i_thr_hi) begin
            cnt_d   = '0;
            state_d = ST_UNLOCKED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_q   <= '0;
      vld1_q  <= 1'b0;
      sq_q    <= '0;
      vld2_q  <= 1'b0;
      acc_q   <= '0;
      pv_q    <= 1'b0;
      peak_q  <= '0;
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
    end else begin
      err_q   <= err_d;
      vld1_q  <= vld1_d;
      sq_q    <= sq_d;
      vld2_q  <= vld2_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
      peak_q  <= peak_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_power       = acc_q[ACC_W-1:SHIFT];
  assign o_power_valid = pv_q;
  assign o_converged   = (state_q == ST_LOCKED);
  assign o_peak        = peak_q;
  assign o_dbg_state   = state_q;
  assign o_dbg_cnt     = cnt_q;

endmodule

// File: tb/tb_err_power_monitor.sv
// Directed bench for err_power_monitor: reset, full-scale impulse and peak
// handling, step response, lock/abort timing, hysteresis and valid gaps.
module tb_err_power_monitor;

  logic        clk;
  logic        rst_n;
  logic [20:0] err;
  logic        vld;
  logic [23:0] thr_lo;
  logic [23:0] thr_hi;
  logic        clr;
  logic [23:0] power;
  logic        pv;
  logic        conv;
  logic [23:0] peak;
  logic [1:0]  dbg_state;
  logic [6:0]  dbg_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];

  err_power_monitor #(
    .NB_DATA(21), .NBF_DATA(20), .NB_POW(24), .SHIFT(6), .HOLD(64)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_error      (err),
    .i_valid      (vld),
    .i_thr_lo     (thr_lo),
    .i_thr_hi     (thr_hi),
    .i_clear_peak (clr),
    .o_power      (power),
    .o_power_valid(pv),
    .o_converged  (conv),
    .o_peak       (peak),
    .o_dbg_state  (dbg_state),
    .o_dbg_cnt    (dbg_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: apply inputs, let one rising edge pass, settle 1 time unit.
  task automatic step(input logic [20:0] e, input logic v);
    err = e;
    vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    err   = '0;
    vld   = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference leaky integrator for the gap test.
  function automatic logic [23:0] sq_of(input logic [20:0] e);
    longint p;
    p = longint'($signed(e)) * longint'($signed(e));
    return 24'(p >>> 17);
  endfunction

  initial begin : main
    int first;
    int drops;
    int over;
    int s_over;
    int below_s;
    int n_pv;
    logic [23:0] prev;
    logic [29:0] acc_m;
    logic [20:0] seq[20];
    logic        seen;

    thr_lo = 24'h000100;
    thr_hi = 24'h001000;
    rst_n  = 1'b0;
    err    = '0;
    vld    = 1'b0;
    clr    = 1'b0;
    #2;
    // Reset state before any clock edge
    check_eq("rst_power", power, 24'h0);
    check_eq("rst_pv", pv, 1'b0);
    check_eq("rst_conv", conv, 1'b0);
    check_eq("rst_peak", peak, 24'h0);

    // Full-scale impulse, peak compare and clear
    do_reset();
    step(21'h100000, 1'b1);
    step(21'h000000, 1'b1);
    check_eq("fs_peak", peak, 24'h800000);
    step(21'h000000, 1'b1);
    check_eq("fs_power_k3", power, 24'h020000);
    check_eq("fs_pv_k3", pv, 1'b1);
    step(21'h000000, 1'b1);
    check_eq("fs_power_decay", power, 24'h01F800);
    check_eq("fs_peak_held", peak, 24'h800000);
    step(21'h000000, 1'b0);
    clr = 1'b1;
    step(21'h000000, 1'b0);
    clr = 1'b0;
    check_eq("clr_idle_peak", peak, 24'h0);
    step(21'h100000, 1'b1);
    step(21'h080000, 1'b1);
    check_eq("peak_reload", peak, 24'h800000);
    clr = 1'b1;
    step(21'h040000, 1'b1);
    clr = 1'b0;
    check_eq("clr_valid_peak", peak, 24'h200000);
    step(21'h0C0000, 1'b1);
    check_eq("peak_smaller", peak, 24'h200000);
    step(21'h000000, 1'b1);
    check_eq("peak_larger", peak, 24'h480000);

    // Step response at 0.5
    do_reset();
    drops = 0;
    over  = 0;
    prev  = '0;
    for (int n = 1; n <= 1200; n++) begin
      step(21'h080000, 1'b1);
      if (n == 3) check_eq("step_p1", power, 24'h008000);
      if (n == 4) check_eq("step_p2", power, 24'h00FE00);
      if (n == 1003) check_eq("step_by_1000", 32'(power >= 24'h1FF800), 32'd1);
      if (power < prev) drops++;
      if (power > 24'h200000) over++;
      prev = power;
    end
    check_eq("step_monotone", drops, 0);
    check_eq("step_no_over", over, 0);
    check_eq("step_final", power, 24'h200000);

    // Lock from reset with zero error
    do_reset();
    first = 0;
    for (int s = 1; s <= 200 && first == 0; s++) begin
      step(21'h000000, 1'b1);
      if (s == 4) begin
        check_eq("lock_state_s4", dbg_state, 2'd1);
        check_eq("lock_cnt_s4", dbg_cnt, 7'd1);
      end
      if (s == 5) check_eq("lock_cnt_s5", dbg_cnt, 7'd2);
      if (conv) first = s;
    end
    check_eq("lock_edge", first, 67);

    // Hysteresis: power between thresholds keeps the lock
    drops = 0;
    for (int s = 1; s <= 1000; s++) begin
      step(21'h004000, 1'b1);
      if (!conv) drops++;
    end
    check_eq("hyst_hold_locked", drops, 0);
    check_eq("hyst_power", power, 24'h000800);
    seen   = 1'b0;
    s_over = 0;
    first  = 0;
    for (int s = 1; s <= 300 && first == 0; s++) begin
      step(21'h020000, 1'b1);
      if (seen && s == s_over + 1) begin
        check_eq("hyst_unlock", conv, 1'b0);
        first = s;
      end else if (!seen && power > 24'h001000) begin
        seen   = 1'b1;
        s_over = s;
        check_eq("hyst_not_early", conv, 1'b1);
      end
    end
    check_eq("hyst_unlock_seen", 32'(first != 0), 32'd1);

    // One above-threshold sample at count 63 aborts the lock
    do_reset();
    for (int s = 1; s <= 66; s++) step((s == 64) ? 21'h020000 : 21'h000000, 1'b1);
    check_eq("abort_state_63", dbg_state, 2'd1);
    check_eq("abort_cnt_63", dbg_cnt, 7'd63);
    check_eq("abort_power", power, 24'h000800);
    step(21'h000000, 1'b1);
    check_eq("abort_state", dbg_state, 2'd0);
    check_eq("abort_cnt", dbg_cnt, 7'd0);
    check_eq("abort_conv", conv, 1'b0);
    check_eq("abort_decay", power, 24'h0007E0);
    below_s = 0;
    first   = 0;
    for (int s = 68; s <= 700 && first == 0; s++) begin
      step(21'h000000, 1'b1);
      if (below_s == 0 && power < thr_lo) below_s = s;
      if (conv) first = s;
    end
    check_eq("relock_edge", first, below_s + 64);

    // Asynchronous reset while locked
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_power", power, 24'h0);
    check_eq("arst_pv", pv, 1'b0);
    check_eq("arst_conv", conv, 1'b0);
    check_eq("arst_peak", peak, 24'h0);
    check_eq("arst_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) step(21'h000000, 1'b1);
    check_eq("arst_after_pv", pv, 1'b1);
    check_eq("arst_after_power", power, 24'h0);
    check_eq("arst_after_conv", conv, 1'b0);

    // Valid gaps: power sequence matches the gap-free reference
    seq = '{21'h100000, 21'h080000, 21'h1C0000, 21'h004000, 21'h0C0000,
            21'h1FFFFF, 21'h000001, 21'h0FFFFF, 21'h000000, 21'h040000,
            21'h180000, 21'h020000, 21'h1E0000, 21'h0A0000, 21'h000000,
            21'h000000, 21'h123456, 21'h054321, 21'h1F0000, 21'h008000};
    acc_m = '0;
    for (int i = 0; i < 20; i++) begin
      acc_m = acc_m - (acc_m >> 6) + {6'd0, sq_of(seq[i])};
      exp_q.push_back(acc_m[29:6]);
    end
    do_reset();
    thr_lo = 24'hFFFFFF;
    n_pv   = 0;
    for (int i = 0; i < 24; i++) begin
      step((i < 20) ? seq[i] : 21'h000000, (i < 20));
      if (pv) begin
        n_pv++;
        if (exp_q.size() > 0) check_eq("gap_power", power, exp_q.pop_front());
      end
      step(21'h0AAAAA, 1'b0);
      if (pv) begin
        n_pv++;
        if (exp_q.size() > 0) check_eq("gap_power", power, exp_q.pop_front());
      end
    end
    check_eq("gap_pv_count", n_pv, 20);
    check_eq("gap_queue_empty", exp_q.size(), 0);
    check_eq("gap_cnt", dbg_cnt, 7'd20);
    check_eq("gap_state", dbg_state, 2'd1);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
